// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
// Bus-side encodings live here so the slave-facing constants are defined once.
package wb_cmd_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_ERR       = 2'b01;
  localparam logic [1:0] ST_TIMEOUT   = 2'b10;
  localparam logic [1:0] ST_RETRY_EXH = 2'b11;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer initiator: one valid/ready command in,
// one bus transfer (with rty re-attempts and per-attempt timeout), one response out.
//
// state | meaning
// IDLE  | ready for a command; bus idle
// BUS   | cyc/stb high, waiting for ack/err/rty or timeout
// GAP   | one idle bus cycle between an rty and the re-attempt
// RESP  | response presented, held until rsp_ready_i
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int wb_adr_width   = 3,
  parameter int wb_dat_width   = 8,
  parameter int timeout_cycles = 16,
  parameter int max_retries    = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst_n,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [wb_adr_width-1:0] cmd_adr_i,
  input  logic [wb_dat_width-1:0] cmd_dat_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [wb_dat_width-1:0] rsp_dat_o,
  output logic [1:0]              rsp_status_o,
  output logic [wb_adr_width-1:0] wb_adr_o,
  output logic [wb_dat_width-1:0] wb_dat_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic [2:0]              wb_cti_o,
  output logic [1:0]              wb_bte_o,
  input  logic [wb_dat_width-1:0] wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i
);

  // A zero-retry build still needs a one-bit counter to stay legal.
  localparam int rty_w = (max_retries > 0) ? $clog2(max_retries + 1) : 1;
  localparam int tmo_w = $clog2(timeout_cycles);
  localparam logic [rty_w-1:0] max_rty  = rty_w'(max_retries);
  localparam logic [tmo_w-1:0] tmo_last = tmo_w'(timeout_cycles - 1);

  state_t           state, state_nxt;
  logic [rty_w-1:0] retry_cnt;
  logic [tmo_w-1:0] tmo_cnt;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid_i) state_nxt = BUS;
      BUS: begin
        if (wb_ack_i || wb_err_i)  state_nxt = RESP;
        else if (wb_rty_i)         state_nxt = (retry_cnt < max_rty) ? GAP : RESP;
        else if (tmo_cnt == tmo_last) state_nxt = RESP;
      end
      GAP:  state_nxt = BUS;
      RESP: if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o = (state == IDLE);
    rsp_valid_o = (state == RESP);
    wb_cyc_o    = (state == BUS);
    wb_stb_o    = (state == BUS);
    wb_cti_o    = WB_CTI_CLASSIC;
    wb_bte_o    = WB_BTE_LINEAR;
  end

  // Command latch, counters and response capture.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_we_o      <= 1'b0;
      retry_cnt    <= '0;
      tmo_cnt      <= '0;
      rsp_dat_o    <= '0;
      rsp_status_o <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            wb_adr_o  <= cmd_adr_i;
            wb_dat_o  <= cmd_dat_i;
            wb_we_o   <= cmd_we_i;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            rsp_dat_o    <= wb_we_o ? '0 : wb_dat_i;
            rsp_status_o <= ST_OK;
          end else if (wb_err_i) begin
            rsp_dat_o    <= '0;
            rsp_status_o <= ST_ERR;
          end else if (wb_rty_i) begin
            if (retry_cnt < max_rty) begin
              retry_cnt <= retry_cnt + 1'b1;
            end else begin
              rsp_dat_o    <= '0;
              rsp_status_o <= ST_RETRY_EXH;
            end
          end else if (tmo_cnt == tmo_last) begin
            rsp_dat_o    <= '0;
            rsp_status_o <= ST_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        GAP:  tmo_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master: a scripted slave answers each attempt,
// and a per-command model predicts status, data, strobe count and latency.
module tb_wb_cmd_master;

  localparam int T  = 16;
  localparam int MR = 3;

  logic       wb_clk = 1'b0;
  logic       wb_rst_n = 1'b0;
  logic       cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [2:0] cmd_adr_i = '0;
  logic [7:0] cmd_dat_i = '0;
  logic       rsp_valid_o, rsp_ready_i = 1'b0;
  logic [7:0] rsp_dat_o;
  logic [1:0] rsp_status_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic       wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0] wb_cti_o;
  logic [1:0] wb_bte_o;
  logic [7:0] wb_dat_i = '0;
  logic       wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  wb_cmd_master #(
    .wb_adr_width(3), .wb_dat_width(8), .timeout_cycles(T), .max_retries(MR)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  int n_chk = 0;
  int n_err = 0;
  // Per-attempt slave script: kind bit0=ack bit1=err bit2=rty (0 = silent),
  // dly = stb cycle index (from 0) on which the termination is driven.
  int kind[8];
  int dly[8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_script(input int k, input int d);
    for (int a = 0; a < 8; a++) begin kind[a] = k; dly[a] = d; end
  endtask

  task automatic run_cmd(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                         input logic [7:0] rdata, input int hold);
    int exp_pulses = 0, total = 0, exp_len = 0, exp_st = 0;
    logic [7:0] exp_d = 8'h00;
    int i = 1, pulses = 0, att = 0, gaps = 0, len = 0, lat = 0;
    bit prev = 0, got = 0, done = 0;
    int k;
    // reference model: walk the attempts with ack > err > rty > timeout
    for (int a = 0; a < 8 && !done; a++) begin
      exp_pulses++;
      if (kind[a] == 0 || dly[a] >= T) begin
        total += T; exp_len = T; exp_st = 2; done = 1;
      end else begin
        total += dly[a] + 1; exp_len = dly[a] + 1;
        if (kind[a] & 1)      begin exp_st = 0; exp_d = we ? 8'h00 : rdata; done = 1; end
        else if (kind[a] & 2) begin exp_st = 1; done = 1; end
        else if (a < MR)      total += 1;
        else                  begin exp_st = 3; done = 1; end
      end
    end

    @(negedge wb_clk);
    chk("ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat;
    @(negedge wb_clk);
    cmd_valid_i = 0; cmd_we_i = ~we; cmd_adr_i = 3'($urandom); cmd_dat_i = 8'($urandom);
    while (i <= 200 && !got) begin
      if (i > 1) @(negedge wb_clk);
      chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      if (wb_cyc_o) begin
        if (!prev) begin pulses++; att = 0; end
        chk("bus_adr", wb_adr_o, adr);
        chk("bus_dat", wb_dat_o, dat);
        chk("bus_we", wb_we_o, we);
        chk("ready_busy", cmd_ready_o, 0);
        k = (pulses <= 8) ? kind[pulses-1] : 0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = 8'($urandom);
        if (pulses <= 8 && att == dly[pulses-1] && k != 0) begin
          wb_ack_i = k[0]; wb_err_i = k[1]; wb_rty_i = k[2];
          if (k[0]) wb_dat_i = rdata;
        end
        att++; len = att;
      end else begin
        // terminations outside BUS must be ignored
        wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom); wb_rty_i = 1'($urandom);
        wb_dat_i = 8'($urandom);
        if (rsp_valid_o) begin got = 1; lat = i; end
        else gaps++;
      end
      prev = wb_cyc_o; i++;
    end
    if (!got) begin
      chk("rsp_arrives", 0, 1);
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      return;
    end
    chk("latency", lat, total + 1);
    chk("stb_pulses", pulses, exp_pulses);
    chk("gap_cycles", gaps, pulses - 1);
    chk("last_att_len", len, exp_len);
    chk("rsp_status", rsp_status_o, exp_st);
    chk("rsp_dat", rsp_dat_o, exp_d);
    for (int h = 0; h < hold; h++) begin
      cmd_valid_i = 1;
      @(negedge wb_clk);
      chk("hold_valid", rsp_valid_o, 1);
      chk("hold_status", rsp_status_o, exp_st);
      chk("hold_dat", rsp_dat_o, exp_d);
      chk("hold_no_accept", cmd_ready_o, 0);
      chk("hold_cyc", wb_cyc_o, 0);
    end
    cmd_valid_i = 0;
    chk("held_adr", wb_adr_o, adr);
    chk("held_dat", wb_dat_o, dat);
    rsp_ready_i = 1;
    @(negedge wb_clk);
    rsp_ready_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
    chk("rsp_drop", rsp_valid_o, 0);
    chk("ready_back", cmd_ready_o, 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_dat", rsp_dat_o, 0);
    chk("rst_status", rsp_status_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_wdat", wb_dat_o, 0);
    chk("cti", wb_cti_o, 3'b000);
    chk("bte", wb_bte_o, 2'b00);
    @(negedge wb_clk); @(negedge wb_clk);
    wb_rst_n = 1;

    set_script(1, 1);            run_cmd(1, 3'd0, 8'hA5, 8'h77, 0);
    set_script(1, 1);            run_cmd(0, 3'd1, 8'h00, 8'h3C, 2);
    set_script(4, 1); kind[2] = 1; run_cmd(0, 3'd2, 8'h11, 8'h5A, 0);
    set_script(4, 1);            run_cmd(1, 3'd3, 8'h22, 8'h00, 0);
    set_script(0, 0);            run_cmd(0, 3'd4, 8'h33, 8'hEE, 0);
    set_script(3, 1);            run_cmd(0, 3'd5, 8'h44, 8'hC3, 5);
    set_script(1, T - 1);        run_cmd(0, 3'd6, 8'h55, 8'h99, 0);
    set_script(6, 0);            run_cmd(1, 3'd7, 8'h66, 8'h00, 1);

    for (int n = 0; n < 40; n++) begin
      for (int a = 0; a < 8; a++) begin
        kind[a] = $urandom_range(0, 7);
        case ($urandom_range(0, 9))
          0:       dly[a] = 20;
          1:       dly[a] = T - 1;
          default: dly[a] = $urandom_range(0, 3);
        endcase
      end
      run_cmd(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 5));
    end

    // reset in the middle of a bus attempt
    set_script(0, 0);
    @(negedge wb_clk);
    cmd_valid_i = 1; cmd_we_i = 1; cmd_adr_i = 3'd5; cmd_dat_i = 8'h5C;
    @(negedge wb_clk); cmd_valid_i = 0;
    @(negedge wb_clk);
    chk("pre_rst_cyc", wb_cyc_o, 1);
    wb_rst_n = 0;
    #1;
    chk("async_rst_cyc", wb_cyc_o, 0);
    chk("async_rst_stb", wb_stb_o, 0);
    chk("async_rst_rsp", rsp_valid_o, 0);
    @(negedge wb_clk); @(negedge wb_clk);
    wb_rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge wb_clk);
      chk("post_rst_no_rsp", rsp_valid_o, 0);
      chk("post_rst_ready", cmd_ready_o, 1);
      chk("post_rst_cyc", wb_cyc_o, 0);
    end
    set_script(1, 1);            run_cmd(0, 3'd2, 8'h00, 8'h81, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
